// File: rtl/block_pattern_gen.sv
// block_pattern_gen
// Test-block source for the AUI block datapath. Produces BLOCK_SIZE-bit
// blocks (PRBS31, counter, fixed or alternating pattern) behind a
// valid/ready handshake, with start/stop/burst control, one-shot bit-0
// error injection and a saturating count of accepted blocks.

module block_pattern_gen #(
    parameter int                BLOCK_SIZE = 257,
    parameter int                LFSR_W     = 31,
    parameter logic [LFSR_W-1:0] SEED       = 31'h7FFF_FFFF,
    parameter int                BURST_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_config,
    input  logic [BLOCK_SIZE-1:0] i_pattern,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [BURST_W-1:0]    i_burst_len,
    input  logic                  i_err_inject,
    input  logic                  i_ready,
    output logic [BLOCK_SIZE-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_block_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [1:0] MODE_PRBS = 2'd0;
    localparam logic [1:0] MODE_CNT  = 2'd1;
    localparam logic [1:0] MODE_FIX  = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0]  SEED_EFF  = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [1:0]            state_q,    state_d;
    logic [BLOCK_SIZE-1:0] data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic                  done_q,     done_d;
    logic [31:0]           blkCnt_q,   blkCnt_d;
    logic [31:0]           accCnt_q,   accCnt_d;
    logic [LFSR_W-1:0]     lfsr_q,     lfsr_d;
    logic [BURST_W-1:0]    remain_q,   remain_d;
    logic                  errLatch_q, errLatch_d;
    logic                  altPhase_q, altPhase_d;

    logic                  startFire;
    logic                  runLoad;
    logic                  load;
    logic                  accept;

    logic [LFSR_W-1:0]     lfsrSrc;
    logic [31:0]           cntSrc;
    logic                  altSrc;
    logic                  errSrc;
    logic [BURST_W-1:0]    remSrc;

    logic [LFSR_W-1:0]     prbsState;
    logic                  prbsFb;
    logic [BLOCK_SIZE-1:0] prbsBlock;
    logic [BLOCK_SIZE-1:0] newBlock;

    // Handshake qualifiers. The start cycle itself loads the first block so
    // that it is presented one cycle after i_start; stop always beats a load.
    always_comb begin
        startFire = (state_q == IDLE) && i_start && !i_stop;
        runLoad   = (state_q == RUN) && !i_stop && (!valid_q || i_ready);
        load      = startFire || runLoad;
        accept    = valid_q && i_ready;
    end

    // Generator sources: on the start cycle the block is built from the
    // freshly restarted values rather than the stale registers.
    always_comb begin
        lfsrSrc = startFire ? SEED_EFF : lfsr_q;
        cntSrc  = startFire ? 32'd0 : blkCnt_q;
        altSrc  = startFire ? 1'b0 : altPhase_q;
        errSrc  = i_err_inject || (errLatch_q && !startFire);
        remSrc  = startFire ? i_burst_len : remain_q;
    end

    // Unrolled PRBS31 (x^31 + x^28 + 1): BLOCK_SIZE serial steps per block,
    // first generated bit lands in the MSB, prbsState ends as the next LFSR.
    always_comb begin
        prbsState = lfsrSrc;
        prbsFb    = 1'b0;
        prbsBlock = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            prbsFb    = prbsState[30] ^ prbsState[27];
            prbsState = {prbsState[LFSR_W-2:0], prbsFb};
            prbsBlock[BLOCK_SIZE-1-i] = prbsFb;
        end
    end

    // Candidate block for the current mode, with the optional bit-0 error.
    always_comb begin
        newBlock = '0;
        case (i_config)
            MODE_PRBS: newBlock = prbsBlock;
            MODE_CNT:  newBlock[31:0] = cntSrc;
            MODE_FIX:  newBlock = i_pattern;
            default:   newBlock = altSrc ? ~i_pattern : i_pattern;
        endcase
        newBlock[0] = newBlock[0] ^ errSrc;
    end

    // Next-state logic: accept bookkeeping, start restart, block load and
    // the IDLE/RUN/DRAIN sequencing.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        blkCnt_d   = blkCnt_q;
        accCnt_d   = accCnt_q;
        lfsr_d     = lfsr_q;
        remain_d   = remain_q;
        errLatch_d = errLatch_q || i_err_inject;
        altPhase_d = altPhase_q;

        if (accept) begin
            valid_d = 1'b0;
            if (accCnt_q != 32'hFFFF_FFFF) begin
                accCnt_d = accCnt_q + 32'd1;
            end
        end

        if (startFire) begin
            accCnt_d = 32'd0;
            state_d  = RUN;
        end

        if (load) begin
            data_d     = newBlock;
            valid_d    = 1'b1;
            blkCnt_d   = cntSrc + 32'd1;
            errLatch_d = 1'b0;
            lfsr_d     = (i_config == MODE_PRBS) ? prbsState : lfsrSrc;
            altPhase_d = (i_config == MODE_ALT) ? !altSrc : altSrc;
            remain_d   = (remSrc != '0) ? (remSrc - BURST_ONE) : remSrc;
            state_d    = (remSrc == BURST_ONE) ? DRAIN : RUN;
        end

        case (state_q)
            IDLE: ;
            RUN: begin
                if (i_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!valid_q || accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any pending block immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            blkCnt_q   <= 32'd0;
            accCnt_q   <= 32'd0;
            lfsr_q     <= SEED_EFF;
            remain_q   <= '0;
            errLatch_q <= 1'b0;
            altPhase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            blkCnt_q   <= blkCnt_d;
            accCnt_q   <= accCnt_d;
            lfsr_q     <= lfsr_d;
            remain_q   <= remain_d;
            errLatch_q <= errLatch_d;
            altPhase_q <= altPhase_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_block_cnt = accCnt_q;

endmodule

// File: tb/tb_block_pattern_gen.sv
// tb_block_pattern_gen
// Directed bench for block_pattern_gen: expected blocks are queued when a
// burst is launched and compared as the DUT hands each block over.

module tb_block_pattern_gen;

    localparam int BS = 257;

    logic          clk;
    logic          rst;
    logic [1:0]    i_config;
    logic [BS-1:0] i_pattern;
    logic          i_start;
    logic          i_stop;
    logic [15:0]   i_burst_len;
    logic          i_err_inject;
    logic          i_ready;
    logic [BS-1:0] o_data;
    logic          o_valid;
    logic          o_busy;
    logic          o_done;
    logic [31:0]   o_block_cnt;

    int            vecCount;
    int            missCount;
    int            acceptCount;
    logic [BS-1:0] expQ[$];

    block_pattern_gen #(
        .BLOCK_SIZE (BS),
        .LFSR_W     (31),
        .SEED       (31'h7FFF_FFFF),
        .BURST_W    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_config     (i_config),
        .i_pattern    (i_pattern),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_burst_len  (i_burst_len),
        .i_err_inject (i_err_inject),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_block_cnt  (o_block_cnt)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [BS-1:0] observed, input logic [BS-1:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock with the current inputs; a block handed over on this
    // edge is popped from the scoreboard and compared first.
    task automatic applyStimulus();
        logic [BS-1:0] expBlk;
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            vecCount++;
            assert (expQ.size() != 0) else begin
                missCount++;
                $error("[TB] FAIL sb_underflow observed=accept expected=no_accept");
            end
            if (expQ.size() != 0) begin
                expBlk = expQ.pop_front();
                checkOutput("sb_block", o_data, expBlk);
            end
            acceptCount++;
        end
        @(posedge clk);
        #1;
    endtask

    // Serial reference PRBS31: one bit per step, first bit into the MSB.
    task automatic prbsRef(inout logic [30:0] s, output logic [BS-1:0] blk);
        logic fb;
        blk = '0;
        for (int i = 0; i < BS; i++) begin
            fb = s[30] ^ s[27];
            s = {s[29:0], fb};
            blk[BS-1-i] = fb;
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic [30:0]   lfsrM;
        logic [BS-1:0] blk0, blk1, blk2, firstBlk;
        logic [BS-1:0] patAlt;
        logic [BS-1:0] onesPat;
        logic [BS-1:0] tmp;
        int            doneSeen;
        int            acceptBase;

        vecCount = 0;
        missCount = 0;
        acceptCount = 0;
        rst = 1'b1;
        i_config = 2'b00;
        i_pattern = '0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_burst_len = 16'd0;
        i_err_inject = 1'b0;
        i_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_cnt", o_block_cnt, 0);
        checkOutput("rst_data", o_data, 0);
        rst = 1'b0;
        applyStimulus();

        // PRBS, burst of 1
        lfsrM = 31'h7FFF_FFFF;
        prbsRef(lfsrM, firstBlk);
        expQ.push_back(firstBlk);
        i_config = 2'b00;
        i_burst_len = 16'd1;
        i_ready = 1'b1;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        checkOutput("t1_valid", o_valid, 1);
        checkOutput("t1_busy", o_busy, 1);
        tmp = o_data;
        checkOutput("t1_msbs", tmp[256:228], 29'h1);
        applyStimulus();
        checkOutput("t1_done", o_done, 1);
        checkOutput("t1_cnt", o_block_cnt, 1);
        checkOutput("t1_valid_low", o_valid, 0);
        applyStimulus();
        checkOutput("t1_done_pulse", o_done, 0);
        checkOutput("t1_idle", o_busy, 0);

        // Counter, burst of 4
        for (int k = 0; k < 4; k++) expQ.push_back(BS'(k));
        i_config = 2'b01;
        i_burst_len = 16'd4;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            if (o_done === 1'b1) doneSeen++;
        end
        checkOutput("t2_done_count", doneSeen, 1);
        checkOutput("t2_cnt", o_block_cnt, 4);
        checkOutput("t2_busy", o_busy, 0);
        checkOutput("t2_drained", expQ.size(), 0);

        // Start together with stop: nothing starts
        i_start = 1'b1;
        i_stop = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        i_stop = 1'b0;
        checkOutput("ss_busy", o_busy, 0);
        checkOutput("ss_valid", o_valid, 0);
        checkOutput("ss_cnt", o_block_cnt, 4);

        // Alternate pattern, burst of 3, ready toggling
        patAlt = {1'b1, {64{4'h5}}};
        expQ.push_back(patAlt);
        expQ.push_back(~patAlt);
        expQ.push_back(patAlt);
        i_config = 2'b11;
        i_pattern = patAlt;
        i_burst_len = 16'd3;
        i_ready = 1'b0;
        i_start = 1'b1;
        acceptBase = acceptCount;
        applyStimulus();
        i_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_ready = (k % 2 == 1);
            if (o_valid === 1'b1 && expQ.size() != 0) checkOutput("t3_present", o_data, expQ[0]);
            applyStimulus();
        end
        checkOutput("t3_accepts", acceptCount - acceptBase, 3);
        checkOutput("t3_cnt", o_block_cnt, 3);
        checkOutput("t3_busy", o_busy, 0);

        // Fixed all-ones, continuous, error on block 5, stop on block 10
        onesPat = '1;
        for (int k = 0; k <= 10; k++) begin
            tmp = onesPat;
            if (k == 5) tmp[0] = 1'b0;
            expQ.push_back(tmp);
        end
        i_config = 2'b10;
        i_pattern = onesPat;
        i_burst_len = 16'd0;
        i_ready = 1'b1;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            i_err_inject = (k == 5);
            applyStimulus();
        end
        i_err_inject = 1'b0;
        i_ready = 1'b0;
        i_stop = 1'b1;
        applyStimulus();
        i_stop = 1'b0;
        checkOutput("t4_held_valid", o_valid, 1);
        checkOutput("t4_drain_busy", o_busy, 1);
        checkOutput("t4_no_done", o_done, 0);
        checkOutput("t4_held_data", o_data, expQ[0]);
        i_ready = 1'b1;
        applyStimulus();
        checkOutput("t4_done", o_done, 1);
        checkOutput("t4_valid_low", o_valid, 0);
        checkOutput("t4_cnt", o_block_cnt, 11);
        checkOutput("t4_drained", expQ.size(), 0);

        // Mode change while a PRBS block is held
        expQ.push_back(firstBlk);
        expQ.push_back(BS'(1));
        i_config = 2'b00;
        i_burst_len = 16'd2;
        i_ready = 1'b0;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        i_config = 2'b01;
        for (int k = 0; k < 2; k++) begin
            applyStimulus();
            checkOutput("t5_hold", o_data, firstBlk);
        end
        i_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t5_done", o_done, 1);
        checkOutput("t5_drained", expQ.size(), 0);

        // Async reset mid-burst, then restart reproduces the first block
        lfsrM = 31'h7FFF_FFFF;
        prbsRef(lfsrM, blk0);
        prbsRef(lfsrM, blk1);
        prbsRef(lfsrM, blk2);
        expQ.push_back(blk0);
        expQ.push_back(blk1);
        i_config = 2'b00;
        i_burst_len = 16'd0;
        i_ready = 1'b1;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        applyStimulus();
        applyStimulus();
        i_ready = 1'b0;
        applyStimulus();
        checkOutput("t6_third_block", o_data, blk2);
        checkOutput("t6_cnt_before", o_block_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_valid", o_valid, 0);
        checkOutput("t6_rst_busy", o_busy, 0);
        checkOutput("t6_rst_cnt", o_block_cnt, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expQ.push_back(firstBlk);
        i_burst_len = 16'd1;
        i_ready = 1'b1;
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        checkOutput("t6_restart_block", o_data, blk0);
        applyStimulus();
        checkOutput("t6_done", o_done, 1);
        checkOutput("t6_cnt", o_block_cnt, 1);
        checkOutput("t6_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
